// File: rtl/truth_sweep_pkg.sv
// Shared types and helpers for the truth-table sweep controller.
package truth_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } sweep_state_t;

  // Truth-table width for an n-input function.
  function automatic int unsigned tbl_w(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/truth_sweep_ctrl.sv
// Walks vec through all 2^N input combinations of an external combinational
// function, captures its output into a truth table, counts the ones and
// flags a difference against an expected table latched at start.
module truth_sweep_ctrl
  import truth_sweep_pkg::*;
#(
  parameter int unsigned N = 4,
  localparam int unsigned W = tbl_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         hold,
  input  logic [W-1:0] expected,
  output logic [N-1:0] vec,
  input  logic         s,
  output logic [W-1:0] table_q,
  output logic [N:0]   ones,
  output logic         busy,
  output logic         done,
  output logic         mismatch
);

  sweep_state_t state, state_nx;

  logic [N-1:0] idx;
  logic [W-1:0] exp_q;
  logic [W-1:0] table_nx;
  logic         last;

  // The last index is detected before incrementing, so idx never wraps and
  // vec keeps showing 2^N-1 after the sweep ends.
  assign last = (idx == N'(W - 1));
  assign vec  = idx;

  // Table as it will look after capturing s at the current index; the final
  // mismatch compare needs the last bit included.
  always_comb begin
    table_nx      = table_q;
    table_nx[idx] = s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = EVAL;
        end
      end
      EVAL: begin
        busy = 1'b1;
        if (!hold && last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Index counter, table capture, ones accumulator and mismatch flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      table_q  <= '0;
      ones     <= '0;
      mismatch <= 1'b0;
      exp_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx      <= '0;
            table_q  <= '0;
            ones     <= '0;
            mismatch <= 1'b0;
            exp_q    <= expected;
          end
        end
        EVAL: begin
          if (!hold) begin
            table_q <= table_nx;
            ones    <= ones + {{N{1'b0}}, s};
            if (last) begin
              mismatch <= (table_nx != exp_q);
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Self-checking bench for truth_sweep_ctrl (N=4). The evaluated function is
// modelled as a lookup into a bench-held 16-bit table driven onto s.
module tb_truth_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        hold;
  logic [15:0] expected;
  logic [3:0]  vec;
  logic        s;
  logic [15:0] table_q;
  logic [4:0]  ones;
  logic        busy;
  logic        done;
  logic        mismatch;

  logic [15:0] fn;

  int checks = 0;
  int errors = 0;

  truth_sweep_ctrl #(.N(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .hold     (hold),
    .expected (expected),
    .vec      (vec),
    .s        (s),
    .table_q  (table_q),
    .ones     (ones),
    .busy     (busy),
    .done     (done),
    .mismatch (mismatch)
  );

  assign s = fn[vec];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] f;
    logic [15:0] e;
    int          hold_at;
    int          hold_len;
    int          restart_at;
    logic [15:0] tab;
    int          n_ones;
    logic        mm;
    int          lat;
  } sweep_vec_t;

  sweep_vec_t tv[7];

  // One full sweep: start is applied before edge E0; latency counts edges
  // from E0 (inclusive) until done is observed, so a plain sweep gives 17.
  task automatic do_sweep(input string name, input logic [15:0] f,
                          input logic [15:0] e, input int hold_at,
                          input int hold_len, input int restart_at,
                          input logic [15:0] exp_tab, input int exp_ones,
                          input logic exp_mm, input int exp_lat);
    int cyc;
    int busy_cyc;
    int hold_left;
    int vec_hold_cnt;
    bit seen;
    logic [15:0] tab_seen;
    fn = f;
    @(negedge clk);
    start    = 1'b1;
    expected = e;
    hold     = 1'b0;
    @(posedge clk);
    #1;
    start        = 1'b0;
    expected     = ~e;
    cyc          = 1;
    busy_cyc     = 0;
    vec_hold_cnt = 0;
    hold_left    = hold_len;
    seen         = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) busy_cyc++;
        if (busy && hold_at >= 0 && int'(vec) == hold_at) vec_hold_cnt++;
        hold = (hold_at >= 0 && int'(vec) == hold_at && hold_left > 0);
        if (hold) hold_left--;
        start = (restart_at >= 0 && int'(vec) == restart_at);
        @(posedge clk);
        cyc++;
      end
    end
    hold = 1'b0;
    if (!seen) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles, expected %0d", name, cyc, exp_lat);
    end
    chk({name, " latency"}, cyc, exp_lat);
    chk({name, " busy_cycles"}, busy_cyc, exp_lat - 1);
    chk({name, " table"}, int'(table_q), int'(exp_tab));
    chk({name, " ones"}, int'(ones), exp_ones);
    chk({name, " mismatch"}, int'(mismatch), int'(exp_mm));
    chk({name, " vec_in_done"}, int'(vec), 15);
    if (hold_at >= 0) chk({name, " vec_hold_count"}, vec_hold_cnt, hold_len + 1);
    tab_seen = table_q;
    // start while DONE must be dropped; done must be a single-cycle pulse
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk({name, " done_pulse_width"}, int'(done), 0);
    chk({name, " start_in_done_ignored"}, int'(busy), 0);
    chk({name, " table_held"}, int'(table_q), int'(tab_seen));
  endtask

  initial begin
    rst_n    = 1'b1;
    start    = 1'b0;
    hold     = 1'b0;
    expected = '0;
    fn       = 16'h0F2A;

    //       f         e         hold_at len restart tab       ones mm    lat
    tv[0] = '{16'h0F2A, 16'h0F2A, -1, 0, -1, 16'h0F2A, 7,  1'b0, 17};
    tv[1] = '{16'h0F2A, 16'h0F2B, -1, 0, -1, 16'h0F2A, 7,  1'b1, 17};
    tv[2] = '{16'h0F2A, 16'h0F2A,  5, 3, -1, 16'h0F2A, 7,  1'b0, 20};
    tv[3] = '{16'hFFFF, 16'hFFFF, -1, 0,  8, 16'hFFFF, 16, 1'b0, 17};
    tv[4] = '{16'h0000, 16'h0000, -1, 0, -1, 16'h0000, 0,  1'b0, 17};
    tv[5] = '{16'h0001, 16'h8000,  0, 2, -1, 16'h0001, 1,  1'b1, 19};
    tv[6] = '{16'h8000, 16'h8000, 15, 1, -1, 16'h8000, 1,  1'b0, 18};

    // Reset for two cycles with start held high
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst vec", int'(vec), 0);
    chk("rst table", int'(table_q), 0);
    chk("rst ones", int'(ones), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst mismatch", int'(mismatch), 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst idle", int'(busy), 0);

    // Table-driven sweeps
    for (int i = 0; i < 7; i++) begin
      do_sweep($sformatf("tv%0d", i), tv[i].f, tv[i].e, tv[i].hold_at,
               tv[i].hold_len, tv[i].restart_at, tv[i].tab, tv[i].n_ones,
               tv[i].mm, tv[i].lat);
    end

    // Reset mid-sweep at idx 10: everything clears, no done follows
    begin
      int guard;
      bit saw_done;
      fn = 16'h0F2A;
      @(negedge clk);
      start    = 1'b1;
      expected = 16'h0F2A;
      @(posedge clk);
      #1 start = 1'b0;
      guard = 0;
      @(negedge clk);
      while (vec != 4'd10 && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      chk("midrst reached_idx10", int'(vec), 10);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("midrst vec", int'(vec), 0);
      chk("midrst table", int'(table_q), 0);
      chk("midrst ones", int'(ones), 0);
      chk("midrst busy", int'(busy), 0);
      chk("midrst mismatch", int'(mismatch), 0);
      rst_n = 1'b1;
      saw_done = 1'b0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (done || busy) saw_done = 1'b1;
      end
      chk("midrst no_done", int'(saw_done), 0);
      do_sweep("after_rst", 16'h0F2A, 16'h0F2A, -1, 0, -1, 16'h0F2A, 7, 1'b0, 17);
    end

    // Randomized sweeps against a table-level reference
    for (int r = 0; r < 12; r++) begin
      logic [15:0] f;
      logic [15:0] e;
      int ha;
      int hl;
      f  = 16'($urandom);
      e  = ($urandom_range(0, 1) == 1) ? f : (f ^ (16'h1 << $urandom_range(0, 15)));
      ha = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 15));
      hl = (ha < 0) ? 0 : int'($urandom_range(0, 3));
      do_sweep($sformatf("rnd%0d", r), f, e, ha, hl, -1, f, $countones(f),
               f != e, 17 + hl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
